// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_NAND = 3'b011;
    localparam logic [2:0] ALU_SHL  = 3'b100;
    localparam logic [2:0] ALU_SHR  = 3'b101;
    localparam logic [2:0] ALU_ASR  = 3'b110;
    localparam logic [2:0] ALU_MUL  = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE,
        S_MUL_RUN
    } alu_state_e;

    localparam int unsigned FLAG_N = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_V = 3;

endpackage

// File: rtl/seq_alu_mul.sv
// Iterative shift-add unsigned multiplier; one multiplier bit per cycle, WIDTH cycles per product.
module seq_alu_mul #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 go,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    localparam int unsigned CntW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] acc_step;
    logic               last;

    always_comb begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        last     = busy_q && (cnt_q == CntW'(WIDTH - 1));
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
            end
        end else if (go) begin
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // done/prod describe the final iteration so the parent can register the product that same edge.
    assign busy = busy_q;
    assign done = last;
    assign prod = acc_step;

endmodule

// File: rtl/seq_alu.sv
// Registered WIDTH-generic ALU with start/busy/done handshake, N/Z/C/V flags and iterative multiply.
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SHW   = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             n_flag,
    output logic             z_flag,
    output logic             c_flag,
    output logic             v_flag
);

    localparam logic [WIDTH-1:0] WidthVal = WIDTH'(WIDTH);
    localparam int unsigned      Msb      = WIDTH - 1;

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic               mul_go, mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum, diff;
    logic [SHW-1:0]     shamt;
    logic               shift_over;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_v;

    seq_alu_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk    (clk),
        .resetn (resetn),
        .go     (mul_go),
        .a      (a),
        .b      (b),
        .busy   (mul_busy),
        .done   (mul_done),
        .prod   (mul_prod)
    );

    // Single-cycle datapath; b is the full shift amount, low SHW bits suffice once b < WIDTH.
    always_comb begin
        sum        = {1'b0, a} + {1'b0, b};
        diff       = {1'b0, a} - {1'b0, b};
        shamt      = b[SHW-1:0];
        shift_over = (b >= WidthVal);
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (op)
            ALU_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[Msb] == b[Msb]) && (alu_res[Msb] != a[Msb]);
            end
            ALU_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (a[Msb] != b[Msb]) && (alu_res[Msb] != a[Msb]);
            end
            ALU_OR:   alu_res = a | b;
            ALU_NAND: alu_res = ~(a & b);
            ALU_SHL:  alu_res = shift_over ? '0 : (a << shamt);
            ALU_SHR:  alu_res = shift_over ? '0 : (a >> shamt);
            ALU_ASR:  alu_res = shift_over ? {WIDTH{a[Msb]}} : WIDTH'($signed(a) >>> shamt);
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;
        done_d      = 1'b0;
        mul_go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op == ALU_MUL) begin
                        mul_go  = 1'b1;
                        state_d = S_MUL_RUN;
                    end else begin
                        result_d        = alu_res;
                        result_hi_d     = '0;
                        flags_d[FLAG_N] = alu_res[Msb];
                        flags_d[FLAG_Z] = (alu_res == '0);
                        flags_d[FLAG_C] = alu_c;
                        flags_d[FLAG_V] = alu_v;
                        done_d          = 1'b1;
                    end
                end
            end
            S_MUL_RUN: begin
                if (mul_done) begin
                    result_d        = mul_prod[WIDTH-1:0];
                    result_hi_d     = mul_prod[2*WIDTH-1:WIDTH];
                    flags_d[FLAG_N] = mul_prod[Msb];
                    flags_d[FLAG_Z] = (mul_prod == '0);
                    flags_d[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    flags_d[FLAG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
                    done_d          = 1'b1;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
            done_q      <= done_d;
        end
    end

    assign busy      = (state_q == S_MUL_RUN) && mul_busy;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign n_flag    = flags_q[FLAG_N];
    assign z_flag    = flags_q[FLAG_Z];
    assign c_flag    = flags_q[FLAG_C];
    assign v_flag    = flags_q[FLAG_V];

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=8.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             n_flag, z_flag, c_flag, v_flag;

    int n_checks = 0;
    int n_errors = 0;

    seq_alu #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .result_hi (result_hi),
        .n_flag    (n_flag),
        .z_flag    (z_flag),
        .c_flag    (c_flag),
        .v_flag    (v_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic [3:0] nzcv);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " result"}, 32'(result), 32'(res));
        check({tag, " nzcv"}, 32'({n_flag, z_flag, c_flag, v_flag}), 32'(nzcv));
    endtask

    // Drive a start for one cycle; returns at the negedge where done is expected.
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int extra_done;
        resetn = 1'b0;
        start  = 1'b0;
        op     = ALU_ADD;
        a      = '0;
        b      = '0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset flags", 32'({n_flag, z_flag, c_flag, v_flag}), 32'd0);
        resetn = 1'b1;

        run_op(ALU_ADD, 8'h7F, 8'h01); check_out("add 7f+1", 8'h80, 4'b1001);
        run_op(ALU_ADD, 8'hFF, 8'h01); check_out("add ff+1", 8'h00, 4'b0110);
        run_op(ALU_SUB, 8'h05, 8'h05); check_out("sub 5-5", 8'h00, 4'b0110);
        run_op(ALU_SUB, 8'h03, 8'h05); check_out("sub 3-5", 8'hFE, 4'b1000);
        @(negedge clk);
        check("done one cycle", 32'(done), 32'd0);
        check("result held", 32'(result), 32'hFE);

        // MUL: busy for 8 cycles, a stray start mid-run must be ignored
        @(negedge clk);
        start = 1'b1; op = ALU_MUL; a = 8'h12; b = 8'h34;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (i == 2) begin
                op = ALU_ADD; a = 8'h01; b = 8'h01;
            end
            check($sformatf("mul busy %0d", i), 32'(busy), 32'd1);
            check($sformatf("mul nodone %0d", i), 32'(done), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        check_out("mul 12*34", 8'hA8, 4'b1011);
        check("mul busy end", 32'(busy), 32'd0);
        check("mul hi", 32'(result_hi), 32'h03);
        @(negedge clk);
        check("mul no extra done", 32'(done), 32'd0);
        check("mul no extra busy", 32'(busy), 32'd0);

        run_op(ALU_SHL, 8'h81, 8'd9);   check_out("shl by 9", 8'h00, 4'b0100);
        check("hi cleared", 32'(result_hi), 32'h00);
        run_op(ALU_SHR, 8'h81, 8'd1);   check_out("shr by 1", 8'h40, 4'b0000);
        run_op(ALU_ASR, 8'h80, 8'd3);   check_out("asr by 3", 8'hF0, 4'b1000);
        run_op(ALU_ASR, 8'h80, 8'd200); check_out("asr by 200", 8'hFF, 4'b1000);
        run_op(ALU_SHL, 8'h81, 8'd0);   check_out("shl by 0", 8'h81, 4'b1000);
        run_op(ALU_SHR, 8'h81, 8'd16);  check_out("shr by 16", 8'h00, 4'b0100);

        // Back-to-back OR then NAND
        @(negedge clk);
        start = 1'b1; op = ALU_OR; a = 8'hF0; b = 8'h0F;
        @(negedge clk);
        check_out("b2b or", 8'hFF, 4'b1000);
        op = ALU_NAND; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check_out("b2b nand", 8'h00, 4'b0100);
        @(negedge clk);
        check("b2b done drop", 32'(done), 32'd0);

        // MUL, then reset at t+4
        run_op(ALU_MUL, 8'hFF, 8'hFF);
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst hi", 32'(result_hi), 32'd0);
        check("rst flags", 32'({n_flag, z_flag, c_flag, v_flag}), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        check("rst no done", 32'(extra_done), 32'd0);
        run_op(ALU_ADD, 8'h01, 8'h02); check_out("add after rst", 8'h03, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
